// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - device, processor and interrupt signals of the I/O port unit
interface io_port_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] dev_data;
   logic             dev_valid;
   logic             dev_ready;
   logic             rd_en;
   logic [WIDTH-1:0] In_Port;
   logic             in_empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] Out_Port;
   logic             out_strobe;
   logic             irq_en;
   logic             irq_ack;
   logic             interupt;

   modport master (
      output dev_data, dev_valid, rd_en, wr_en, wr_data, irq_en, irq_ack,
      input  dev_ready, In_Port, in_empty, count, overflow, Out_Port, out_strobe, interupt
   );

   modport slave (
      input  dev_data, dev_valid, rd_en, wr_en, wr_data, irq_en, irq_ack,
      output dev_ready, In_Port, in_empty, count, overflow, Out_Port, out_strobe, interupt
   );
endinterface

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - buffered input FIFO, strobed output port and interrupt FSM
module io_port_ctrl #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int IRQ_LEVEL = 1
) (
   input logic           clk,
   input logic           reset,
   io_port_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_IRQ  = CNT_W'(IRQ_LEVEL);

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             strobe_q, strobe_d;
   irq_state_t       state_q, state_d;

   logic full, empty, push, pop;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign push  = bus.dev_valid && !full;
   assign pop   = bus.rd_en && !empty;

   assign bus.dev_ready  = !full;
   assign bus.in_empty   = empty;
   assign bus.count      = count_q;
   assign bus.overflow   = overflow_q;
   assign bus.In_Port    = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.Out_Port   = out_q;
   assign bus.out_strobe = strobe_q;

   // Next state of FIFO pointers, occupancy, sticky overflow and output port
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      overflow_d = overflow_q || (bus.dev_valid && full);
      out_d      = bus.wr_en ? bus.wr_data : out_q;
      strobe_d   = bus.wr_en;
   end

   // Control registers; reset discards queued words by clearing pointers and count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         out_q      <= '0;
         strobe_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         out_q      <= out_d;
         strobe_q   <= strobe_d;
      end
   end

   // FIFO storage; no reset needed since the head is masked while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.dev_data;
      end
   end

   // Interrupt FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IRQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Interrupt FSM next state; SERVICE blocks retrigger until drained below the level
   always_comb begin
      state_d = state_q;
      case (state_q)
         IRQ_IDLE: begin
            if (bus.irq_en && (count_q >= CNT_IRQ)) state_d = IRQ_REQ;
         end
         IRQ_REQ: begin
            if (!bus.irq_en)     state_d = IRQ_IDLE;
            else if (bus.irq_ack) state_d = IRQ_SERVICE;
         end
         IRQ_SERVICE: begin
            if (count_q < CNT_IRQ) state_d = IRQ_IDLE;
         end
         default: state_d = IRQ_IDLE;
      endcase
   end

   // Interrupt FSM output; decoded from the state register only
   always_comb begin
      bus.interupt = (state_q == IRQ_REQ);
   end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - randomized and directed bench for io_port_ctrl
module tb_io_port_ctrl;
   localparam int WIDTH     = 16;
   localparam int DEPTH     = 4;
   localparam int IRQ_LEVEL = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   io_port_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   io_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int tests_run = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] mq[$];
   bit               m_ovf;
   logic [WIDTH-1:0] m_out;
   bit               m_strobe;
   bit               m_irq;
   bit               m_hold;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int occ;
      bit full;
      bit empty;
      occ   = mq.size();
      full  = (occ == DEPTH);
      empty = (occ == 0);
      if (reset) begin
         mq.delete();
         m_ovf    = 1'b0;
         m_out    = '0;
         m_strobe = 1'b0;
         m_irq    = 1'b0;
         m_hold   = 1'b0;
      end else begin
         if (bus.rd_en && !empty) void'(mq.pop_front());
         if (bus.dev_valid && !full) mq.push_back(bus.dev_data);
         if (bus.dev_valid && full) m_ovf = 1'b1;
         if (bus.wr_en) m_out = bus.wr_data;
         m_strobe = bus.wr_en;
         if (m_irq) begin
            if (!bus.irq_en) m_irq = 1'b0;
            else if (bus.irq_ack) begin
               m_irq  = 1'b0;
               m_hold = 1'b1;
            end
         end else if (m_hold) begin
            if (occ < IRQ_LEVEL) m_hold = 1'b0;
         end else if (bus.irq_en && occ >= IRQ_LEVEL) begin
            m_irq = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      int occ;
      occ = mq.size();
      check("count", 32'(bus.count), 32'(occ));
      check("in_empty", 32'(bus.in_empty), 32'(occ == 0));
      check("dev_ready", 32'(bus.dev_ready), 32'(occ < DEPTH));
      check("In_Port", 32'(bus.In_Port), (occ != 0) ? 32'(mq[0]) : 32'd0);
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("Out_Port", 32'(bus.Out_Port), 32'(m_out));
      check("out_strobe", 32'(bus.out_strobe), 32'(m_strobe));
      check("interupt", 32'(bus.interupt), 32'(m_irq));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic clear_pulses();
      reset         = 1'b0;
      bus.dev_valid = 1'b0;
      bus.rd_en     = 1'b0;
      bus.wr_en     = 1'b0;
      bus.irq_ack   = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      bus.dev_valid = 1'b1;
      bus.dev_data  = w;
      tick();
      bus.dev_valid = 1'b0;
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] words [4];
      words = '{16'h0005, 16'h0019, 16'hFFFF, 16'hF320};
      bus.dev_data = '0;
      bus.wr_data  = '0;
      bus.irq_en   = 1'b0;
      clear_pulses();
      m_ovf = 1'b0; m_out = '0; m_strobe = 1'b0; m_irq = 1'b0; m_hold = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_ready", 32'(bus.dev_ready), 32'd1);

      // fill, overflow, drain in order
      for (int i = 0; i < 4; i++) push(words[i]);
      check("fill_count", 32'(bus.count), 32'd4);
      check("fill_ready", 32'(bus.dev_ready), 32'd0);
      push(16'h1234);
      check("ovf_set", 32'(bus.overflow), 32'd1);
      check("ovf_head", 32'(bus.In_Port), 32'h0005);
      for (int i = 0; i < 4; i++) begin
         check("pop_order", 32'(bus.In_Port), 32'(words[i]));
         pop();
      end
      check("drained_port", 32'(bus.In_Port), 32'd0);
      check("drained_empty", 32'(bus.in_empty), 32'd1);
      pop();
      check("empty_pop_count", 32'(bus.count), 32'd0);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);

      // wrap-around: push two, pop one
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c % 3 == 2) pop();
         else push(WIDTH'($urandom));
      end
      check("wrap_count", 32'(bus.count), 32'd4);
      for (int i = 0; i < 4; i++) pop();
      do_reset();
      push(16'hAAAA);
      push(16'hBBBB);
      bus.dev_valid = 1'b1;
      bus.dev_data  = 16'hCCCC;
      bus.rd_en     = 1'b1;
      tick();
      clear_pulses();
      check("simul_count", 32'(bus.count), 32'd2);
      check("simul_head", 32'(bus.In_Port), 32'hBBBB);

      // interrupt sequencing at level 2
      do_reset();
      bus.irq_en = 1'b1;
      push(16'h0001);
      push(16'h0002);
      check("irq_not_yet", 32'(bus.interupt), 32'd0);
      tick();
      check("irq_raised", 32'(bus.interupt), 32'd1);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      check("irq_acked", 32'(bus.interupt), 32'd0);
      push(16'h0003);
      tick();
      check("irq_no_retrig", 32'(bus.interupt), 32'd0);
      pop();
      pop();
      tick();
      push(16'h0004);
      tick();
      check("irq_reassert", 32'(bus.interupt), 32'd1);
      bus.irq_en = 1'b0;
      tick();
      check("irq_en_drop", 32'(bus.interupt), 32'd0);

      // output port back-to-back writes
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h00AB;
      tick();
      check("out_ab", 32'(bus.Out_Port), 32'h00AB);
      check("strobe_1", 32'(bus.out_strobe), 32'd1);
      bus.wr_data = 16'h00CD;
      tick();
      check("out_cd", 32'(bus.Out_Port), 32'h00CD);
      check("strobe_2", 32'(bus.out_strobe), 32'd1);
      bus.wr_en = 1'b0;
      tick();
      check("strobe_off", 32'(bus.out_strobe), 32'd0);

      // reset mid-operation
      do_reset();
      bus.irq_en = 1'b1;
      push(16'h0101);
      push(16'h0202);
      push(16'h0303);
      check("pre_rst_irq", 32'(bus.interupt), 32'd1);
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h5A5A;
      tick();
      bus.wr_en = 1'b0;
      do_reset();
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_irq", 32'(bus.interupt), 32'd0);
      check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
      check("mid_rst_out", 32'(bus.Out_Port), 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset         = ($urandom_range(0, 99) == 0);
         bus.dev_valid = 1'($urandom_range(0, 1));
         bus.dev_data  = WIDTH'($urandom);
         bus.rd_en     = 1'($urandom_range(0, 2) == 0);
         bus.wr_en     = 1'($urandom_range(0, 3) == 0);
         bus.wr_data   = WIDTH'($urandom);
         bus.irq_en    = ($urandom_range(0, 7) != 0);
         bus.irq_ack   = ($urandom_range(0, 3) == 0);
         tick();
      end
      clear_pulses();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
